seg_scan_ctl: RTL and testbench

SEG_SCAN_CTL -- requirements
Module: seg_scan_ctl

---
 rtl/seg_scan_ctl_pkg.sv | 13 +
 rtl/seg_scan_ctl_hex.sv | 30 +++
 rtl/seg_scan_ctl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctl_pkg.sv
// Shared constants and scan FSM state type for the multiplexed seven-segment
// display controller.
package seg_scan_ctl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctl_hex.sv
// Nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_seven_segment_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seven_segment
);

  always_comb begin
    seven_segment = 7'h7F;
    case (hex)
      4'h0: seven_segment = 7'h40;
      4'h1: seven_segment = 7'h79;
      4'h2: seven_segment = 7'h24;
      4'h3: seven_segment = 7'h30;
      4'h4: seven_segment = 7'h19;
      4'h5: seven_segment = 7'h12;
      4'h6: seven_segment = 7'h02;
      4'h7: seven_segment = 7'h78;
      4'h8: seven_segment = 7'h00;
      4'h9: seven_segment = 7'h10;
      4'hA: seven_segment = 7'h08;
      4'hB: seven_segment = 7'h03;
      4'hC: seven_segment = 7'h46;
      4'hD: seven_segment = 7'h21;
      4'hE: seven_segment = 7'h06;
      4'hF: seven_segment = 7'h0E;
      default: seven_segment = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctl.sv
// Four-digit time-multiplexed display scanner with a blanking gap per slot and
// tear-free (frame-boundary) update of the displayed value.
module seg_scan_ctl
  import seg_scan_ctl_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SECOND = 100_000_000,
  parameter int unsigned DWELL_CYCLES      = CYCLES_PER_SECOND / 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seven_segment,
  output logic        frame_done
);

  localparam int unsigned CYC_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DWELL_CYCLES - 1);

  scan_state_t      state, state_next;
  logic [CYC_W-1:0] cyc, cyc_next;
  logic [1:0]       slot, slot_next;
  logic             frame_end;

  logic [15:0] pending_val;
  logic [3:0]  pending_en;
  logic        pending_valid;
  logic [15:0] shadow_val;
  logic [3:0]  shadow_en;

  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  always_comb begin
    frame_end  = (slot == 2'd3) && (cyc == CYC_LAST);
    cyc_next   = cyc + CYC_W'(1);
    slot_next  = slot;
    state_next = ST_SHOW;
    if (cyc == CYC_LAST) begin
      cyc_next  = '0;
      slot_next = slot + 2'd1;
    end
    // The state tracks the counter: the first clock of every slot is the dark gap.
    if (cyc_next == '0) begin
      state_next = ST_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cyc   <= '0;
      slot  <= '0;
    end else begin
      state <= state_next;
      cyc   <= cyc_next;
      slot  <= slot_next;
    end
  end

  // A load landing on the frame-end clock bypasses the pending stage entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_val   <= '0;
      pending_en    <= '0;
      pending_valid <= 1'b0;
      shadow_val    <= '0;
      shadow_en     <= '0;
    end else if (frame_end) begin
      pending_valid <= 1'b0;
      if (load) begin
        shadow_val <= value;
        shadow_en  <= digit_en;
      end else if (pending_valid) begin
        shadow_val <= pending_val;
        shadow_en  <= pending_en;
      end
    end else if (load) begin
      pending_val   <= value;
      pending_en    <= digit_en;
      pending_valid <= 1'b1;
    end
  end

  assign cur_nib = shadow_val[{slot, 2'b00} +: 4];

  hex_seven_segment_decoder u_dec (
    .hex           (cur_nib),
    .seven_segment (dec_seg)
  );

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (state == ST_SHOW && shadow_en[slot]) begin
      an_next  = ~(4'b0001 << slot);
      seg_next = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an            <= AN_OFF;
      seven_segment <= SEG_BLANK;
      frame_done    <= 1'b0;
    end else begin
      an            <= an_next;
      seven_segment <= seg_next;
      frame_done    <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctl.sv
// Directed bench for seg_scan_ctl with a frame-position reference model and
// hand-computed spot checks.
module tb_seg_scan_ctl;

  localparam int DWELL = 4;
  localparam int FRAME = 4 * DWELL;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seven_segment;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seg_scan_ctl #(
    .CYCLES_PER_SECOND (100_000_000),
    .DWELL_CYCLES      (DWELL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .value         (value),
    .digit_en      (digit_en),
    .an            (an),
    .seven_segment (seven_segment),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Edges since the last reset edge.
  int edge_k = 0;
  always @(posedge clk) begin
    if (rst) edge_k <= 0;
    else     edge_k <= edge_k + 1;
  end

  // Reference model: position within the frame decides everything displayed.
  int          m_pos;
  logic [15:0] m_sh_val, m_pd_val;
  logic [3:0]  m_sh_en, m_pd_en;
  bit          m_pv;
  bit          m_valid = 0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  always @(posedge clk) begin
    int s, ph;
    if (rst) begin
      m_pos = 0; m_sh_val = '0; m_sh_en = '0; m_pd_val = '0; m_pd_en = '0; m_pv = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0; m_valid = 1;
    end else begin
      s  = m_pos / DWELL;
      ph = m_pos % DWELL;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (ph != 0 && m_sh_en[s]) begin
        e_an  = 4'hF & ~(4'd1 << s);
        e_seg = hex_tab[(m_sh_val >> (4 * s)) & 16'hF];
      end
      e_fd = (m_pos == FRAME - 1);
      if (m_pos == FRAME - 1) begin
        if (load) begin m_sh_val = value; m_sh_en = digit_en; end
        else if (m_pv) begin m_sh_val = m_pd_val; m_sh_en = m_pd_en; end
        m_pv = 0;
      end else if (load) begin
        m_pd_val = value; m_pd_en = digit_en; m_pv = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (an !== e_an) begin
        fails++;
        $display("FAIL model_an edge=%0d got=%b expected=%b", edge_k, an, e_an);
      end
      tests++;
      if (seven_segment !== e_seg) begin
        fails++;
        $display("FAIL model_seg edge=%0d got=%h expected=%h", edge_k, seven_segment, e_seg);
      end
      tests++;
      if (frame_done !== e_fd) begin
        fails++;
        $display("FAIL model_frame_done edge=%0d got=%b expected=%b", edge_k, frame_done, e_fd);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_edge(input int k);
    for (int i = 0; i < 2000 && edge_k != k; i++) @(negedge clk);
    if (edge_k != k) chk("wait_timeout", 16'(edge_k), 16'(k));
  endtask

  // Drive a load that the DUT samples on edge k.
  task automatic load_at(input int k, input logic [15:0] v, input logic [3:0] e);
    wait_edge(k - 1);
    load = 1'b1; value = v; digit_en = e;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic at_edge(input string name, input int k, input logic [3:0] xa,
                         input logic [6:0] xs, input logic xf);
    wait_edge(k);
    chk({name, "_an"}, 16'(an), 16'(xa));
    chk({name, "_seg"}, 16'(seven_segment), 16'(xs));
    chk({name, "_fd"}, 16'(frame_done), 16'(xf));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; digit_en = '0;
    repeat (2) @(negedge clk);
    at_edge("reset", 0, 4'hF, 7'h7F, 1'b0);
    rst = 1'b0;

    // 1234 on all digits: dark first frame, then 4,3,2,1 right to left.
    load_at(1, 16'h1234, 4'hF);
    at_edge("dark_f1", 2, 4'hF, 7'h7F, 1'b0);
    at_edge("fd_f1", 16, 4'hF, 7'h7F, 1'b1);
    at_edge("blank_s0", 17, 4'hF, 7'h7F, 1'b0);
    at_edge("d0_4", 18, 4'b1110, 7'h19, 1'b0);
    at_edge("d1_3", 22, 4'b1101, 7'h30, 1'b0);
    at_edge("d2_2", 26, 4'b1011, 7'h24, 1'b0);
    at_edge("d3_1", 30, 4'b0111, 7'h79, 1'b0);
    at_edge("fd_f2", 32, 4'b0111, 7'h79, 1'b1);

    // Mid-frame load must not tear the current frame.
    load_at(40, 16'h0F00, 4'hF);
    at_edge("old_d2", 42, 4'b1011, 7'h24, 1'b0);
    at_edge("old_d3", 46, 4'b0111, 7'h79, 1'b0);
    at_edge("new_d0", 50, 4'b1110, 7'h40, 1'b0);
    at_edge("new_d1", 54, 4'b1101, 7'h40, 1'b0);
    at_edge("new_d2", 58, 4'b1011, 7'h0E, 1'b0);
    at_edge("new_d3", 62, 4'b0111, 7'h40, 1'b0);

    // Two loads in one frame: only the last survives.
    load_at(66, 16'hAAAA, 4'hF);
    load_at(70, 16'hBBBB, 4'hF);
    at_edge("prev_d2", 74, 4'b1011, 7'h0E, 1'b0);
    at_edge("b_d0", 82, 4'b1110, 7'h03, 1'b0);
    at_edge("b_d3", 94, 4'b0111, 7'h03, 1'b0);

    // Load coinciding with frame end commits immediately.
    load_at(96, 16'hCDEF, 4'hF);
    at_edge("coinc_end", 96, 4'b0111, 7'h03, 1'b1);
    chk("pv_after_coinc", 16'(dut.pending_valid), 16'h0);
    at_edge("c_d0_F", 98, 4'b1110, 7'h0E, 1'b0);
    at_edge("c_d1_E", 102, 4'b1101, 7'h06, 1'b0);
    at_edge("c_d2_D", 106, 4'b1011, 7'h21, 1'b0);
    at_edge("c_d3_C", 110, 4'b0111, 7'h46, 1'b0);

    // Partial enable 0101: digits 1 and 3 stay dark.
    load_at(114, 16'h1234, 4'b0101);
    at_edge("en_d0", 130, 4'b1110, 7'h19, 1'b0);
    at_edge("en_d1", 134, 4'hF, 7'h7F, 1'b0);
    at_edge("en_d2", 138, 4'b1011, 7'h24, 1'b0);
    at_edge("en_d3", 142, 4'hF, 7'h7F, 1'b0);
    at_edge("en_fd", 144, 4'hF, 7'h7F, 1'b1);

    // Reset during slot 2 with a load pending.
    load_at(147, 16'h5555, 4'hF);
    wait_edge(153);
    rst = 1'b1;
    @(negedge clk);
    at_edge("midrst", 0, 4'hF, 7'h7F, 1'b0);
    rst = 1'b0;
    at_edge("rst_fd", 16, 4'hF, 7'h7F, 1'b1);
    at_edge("rst_dark1", 18, 4'hF, 7'h7F, 1'b0);
    at_edge("rst_dark2", 34, 4'hF, 7'h7F, 1'b0);
    load_at(36, 16'h0001, 4'b0001);
    at_edge("rst_new", 50, 4'b1110, 7'h79, 1'b0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
